tx_arb: RTL and testbench

TX_ARB -- requirements
Module: tx_arb

---
 rtl/tx_arb_if.sv | 26 ++
 rtl/tx_arb.sv | 140 ++++++++++++++
 tb/tb_tx_arb.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_arb_if.sv
// Bundle between the round-robin transmit arbiter and its requesters/transmitter.
// master is the arbiter side; slave is the requester/transmitter side.
interface tx_arb_if;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned W_DATA = 16;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*W_DATA-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic                    err;
    logic                    busy;
    logic                    trmt;
    logic [W_DATA-1:0]       tx_data;
    logic                    tx_done;

    modport master (
        input  req, req_data, tx_done,
        output gnt, done, err, busy, trmt, tx_data
    );

    modport slave (
        output req, req_data, tx_done,
        input  gnt, done, err, busy, trmt, tx_data
    );
endinterface

// File: rtl/tx_arb.sv
// Four-way round-robin arbiter feeding one 16-bit transmitter, with a per-word
// completion timeout and a programmable idle gap between words.
module tx_arb #(
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic     clk,
    input  logic     rst,
    tx_arb_if.master bus
);
    localparam int unsigned N_REQ   = 4;
    localparam int unsigned W_PTR   = 2;
    localparam int unsigned W_DATA  = 16;
    localparam int unsigned W_TIMER = 16;
    localparam int unsigned W_GAP   = 4;

    localparam logic [W_TIMER-1:0] TIMER_LAST = W_TIMER'(TIMEOUT_CYC - 1);
    localparam logic [W_GAP-1:0]   GAP_LAST   = W_GAP'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state;
    logic [W_PTR-1:0]    ptr;
    logic [W_PTR-1:0]    owner;
    logic [W_TIMER-1:0]  timer;
    logic [W_GAP-1:0]    gap_cnt;

    logic [N_REQ-1:0]    gnt_q;
    logic [N_REQ-1:0]    done_q;
    logic                err_q;
    logic                busy_q;
    logic                trmt_q;
    logic [W_DATA-1:0]   tx_data_q;

    logic                win_valid;
    logic [W_PTR-1:0]    win;
    logic [W_PTR-1:0]    idx;

    // Rotating priority search: scanning offsets high-to-low leaves the
    // requester closest to ptr as the winner.
    always_comb begin
        win_valid = 1'b0;
        win       = ptr;
        idx       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + W_PTR'(i);
            if (bus.req[idx]) begin
                win_valid = 1'b1;
                win       = idx;
            end
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            tx_data_q <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            trmt_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (win_valid) begin
                        tx_data_q <= bus.req_data[W_DATA*win +: W_DATA];
                        owner     <= win;
                        gnt_q     <= N_REQ'(1) << win;
                        trmt_q    <= 1'b1;
                        timer     <= '0;
                        busy_q    <= 1'b1;
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (timer != '1) begin
                        timer <= timer + W_TIMER'(1);
                    end
                    // tx_done in the trmt cycle belongs to an earlier word.
                    if ((bus.tx_done && !trmt_q) || (timer == TIMER_LAST)) begin
                        if (bus.tx_done && !trmt_q) begin
                            done_q <= N_REQ'(1) << owner;
                        end else begin
                            err_q <= 1'b1;
                        end
                        ptr     <= owner + W_PTR'(1);
                        gap_cnt <= '0;
                        if (GAP_CYC == 0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + W_GAP'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.trmt    = trmt_q;
    assign bus.tx_data = tx_data_q;

    // Single outstanding grant and single completion at a time.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done_q));
endmodule

// File: tb/tb_tx_arb.sv
// Directed bench for tx_arb: one default instance (gap 2, long timeout) and one
// with no gap and an 8-cycle timeout.
module tb_tx_arb;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    tx_arb_if a ();
    tx_arb_if b ();

    tx_arb #(.GAP_CYC(2), .TIMEOUT_CYC(1024)) u_dut (.clk(clk), .rst(rst), .bus(a.master));
    tx_arb #(.GAP_CYC(0), .TIMEOUT_CYC(8))    u_to  (.clk(clk), .rst(rst), .bus(b.master));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if ({a.gnt, a.done, a.err, a.trmt, a.busy, a.tx_data} !== 28'h0)
            $display("FAIL reset_a: got gnt=%b done=%b err=%b trmt=%b busy=%b tx_data=%h want all 0",
                     a.gnt, a.done, a.err, a.trmt, a.busy, a.tx_data);
        else n_pass++;
        n_total++;
        if ({b.gnt, b.done, b.err, b.trmt, b.busy, b.tx_data} !== 28'h0)
            $display("FAIL reset_b: got gnt=%b done=%b err=%b trmt=%b busy=%b tx_data=%h want all 0",
                     b.gnt, b.done, b.err, b.trmt, b.busy, b.tx_data);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        a.req      = 4'b0100;
        a.req_data = {16'h0000, 16'hA55A, 16'h0000, 16'h0000};
        tick();
        n_total++;
        if ({a.gnt, a.trmt, a.busy} !== {4'b0100, 1'b1, 1'b1})
            $display("FAIL single_grant: got gnt=%b trmt=%b busy=%b want 0100 1 1", a.gnt, a.trmt, a.busy);
        else n_pass++;
        n_total++;
        if (a.tx_data !== 16'hA55A)
            $display("FAIL single_data: got %h want a55a", a.tx_data);
        else n_pass++;
        a.req     = 4'b0000;
        a.tx_done = 1'b1;
        tick();
        a.tx_done = 1'b0;
        n_total++;
        if ({a.gnt, a.trmt, a.done, a.busy} !== {4'b0000, 1'b0, 4'b0000, 1'b1})
            $display("FAIL single_ignore_in_trmt: got gnt=%b trmt=%b done=%b busy=%b want 0000 0 0000 1",
                     a.gnt, a.trmt, a.done, a.busy);
        else n_pass++;
        repeat (18) tick();
        a.tx_done = 1'b1;
        tick();
        a.tx_done = 1'b0;
        n_total++;
        if ({a.done, a.err, a.busy} !== {4'b0100, 1'b0, 1'b1})
            $display("FAIL single_done: got done=%b err=%b busy=%b want 0100 0 1", a.done, a.err, a.busy);
        else n_pass++;
        tick();
        n_total++;
        if ({a.done, a.busy} !== {4'b0000, 1'b1})
            $display("FAIL single_gap2: got done=%b busy=%b want 0000 1", a.done, a.busy);
        else n_pass++;
        tick();
        n_total++;
        if ({a.busy, a.tx_data} !== {1'b0, 16'hA55A})
            $display("FAIL single_idle: got busy=%b tx_data=%h want 0 a55a", a.busy, a.tx_data);
        else n_pass++;
        a.tx_done = 1'b1;
        tick();
        a.tx_done = 1'b0;
        n_total++;
        if ({a.done, a.busy, a.gnt} !== 9'h0)
            $display("FAIL idle_tx_done: got done=%b busy=%b gnt=%b want 0", a.done, a.busy, a.gnt);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_w [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  exp_g;
        logic [15:0] exp_d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a.req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        a.req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << exp_w[k];
            exp_d = 16'h1111 * 16'(exp_w[k] + 1);
            tick();
            n_total++;
            if ({a.gnt, a.tx_data} !== {exp_g, exp_d})
                $display("FAIL rr_grant%0d: got gnt=%b tx_data=%h want %b %h", k, a.gnt, a.tx_data, exp_g, exp_d);
            else n_pass++;
            tick();
            a.tx_done = 1'b1;
            tick();
            a.tx_done = 1'b0;
            n_total++;
            if (a.done !== exp_g)
                $display("FAIL rr_done%0d: got %b want %b", k, a.done, exp_g);
            else n_pass++;
            tick();
            n_total++;
            if ({a.gnt, a.busy} !== {4'b0000, 1'b1})
                $display("FAIL rr_gap_ignores_req%0d: got gnt=%b busy=%b want 0000 1", k, a.gnt, a.busy);
            else n_pass++;
            tick();
        end
        a.req = 4'b0000;
    endtask

    task automatic test_ptr_skip();
        a.req = 4'b1001;
        tick();
        n_total++;
        if ({a.gnt, a.tx_data} !== {4'b1000, 16'h4444})
            $display("FAIL ptr_skip: got gnt=%b tx_data=%h want 1000 4444", a.gnt, a.tx_data);
        else n_pass++;
        a.req = 4'b0000;
        tick();
        a.tx_done = 1'b1;
        tick();
        a.tx_done = 1'b0;
        tick();
        tick();
        repeat (3) tick();
        n_total++;
        if ({a.gnt, a.trmt, a.busy, a.done, a.err} !== 11'h0)
            $display("FAIL idle_no_req: got gnt=%b trmt=%b busy=%b done=%b err=%b want 0",
                     a.gnt, a.trmt, a.busy, a.done, a.err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        a.req = 4'b0001;
        tick();
        a.req = 4'b0000;
        repeat (4) tick();
        rst       = 1'b1;
        a.req     = 4'b1111;
        a.tx_done = 1'b1;
        tick();
        n_total++;
        if ({a.gnt, a.done, a.err, a.trmt, a.busy, a.tx_data} !== 28'h0)
            $display("FAIL rst_mid_wait: got gnt=%b done=%b err=%b trmt=%b busy=%b tx_data=%h want all 0",
                     a.gnt, a.done, a.err, a.trmt, a.busy, a.tx_data);
        else n_pass++;
        tick();
        n_total++;
        if ({a.gnt, a.busy} !== 5'h0)
            $display("FAIL rst_ignores_req: got gnt=%b busy=%b want 0000 0", a.gnt, a.busy);
        else n_pass++;
        a.req = 4'b0000;
        rst   = 1'b0;
        tick();
        a.tx_done = 1'b0;
        n_total++;
        if ({a.done, a.busy} !== 5'h0)
            $display("FAIL rst_late_tx_done: got done=%b busy=%b want 0000 0", a.done, a.busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        b.req_data = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
        b.req      = 4'b0001;
        tick();
        n_total++;
        if ({b.gnt, b.trmt, b.tx_data} !== {4'b0001, 1'b1, 16'hA0A0})
            $display("FAIL to_grant: got gnt=%b trmt=%b tx_data=%h want 0001 1 a0a0", b.gnt, b.trmt, b.tx_data);
        else n_pass++;
        b.req = 4'b0000;
        for (int c = 2; c <= 8; c++) begin
            tick();
            n_total++;
            if ({b.err, b.done, b.busy} !== {1'b0, 4'b0000, 1'b1})
                $display("FAIL to_wait_cyc%0d: got err=%b done=%b busy=%b want 0 0000 1", c, b.err, b.done, b.busy);
            else n_pass++;
        end
        tick();
        n_total++;
        if ({b.err, b.done, b.busy} !== {1'b1, 4'b0000, 1'b0})
            $display("FAIL to_err: got err=%b done=%b busy=%b want 1 0000 0", b.err, b.done, b.busy);
        else n_pass++;
        tick();
        n_total++;
        if (b.err !== 1'b0)
            $display("FAIL to_err_pulse: got %b want 0", b.err);
        else n_pass++;
        b.req = 4'b0011;
        tick();
        n_total++;
        if ({b.gnt, b.tx_data} !== {4'b0010, 16'hB1B1})
            $display("FAIL to_ptr_advance: got gnt=%b tx_data=%h want 0010 b1b1", b.gnt, b.tx_data);
        else n_pass++;
        b.req = 4'b0001;
        repeat (7) tick();
        b.tx_done = 1'b1;
        tick();
        b.tx_done = 1'b0;
        n_total++;
        if ({b.done, b.err, b.busy} !== {4'b0010, 1'b0, 1'b0})
            $display("FAIL to_tie: got done=%b err=%b busy=%b want 0010 0 0", b.done, b.err, b.busy);
        else n_pass++;
        tick();
        n_total++;
        if ({b.gnt, b.tx_data} !== {4'b0001, 16'hA0A0})
            $display("FAIL nogap_wrap_grant: got gnt=%b tx_data=%h want 0001 a0a0", b.gnt, b.tx_data);
        else n_pass++;
        b.req = 4'b0000;
        tick();
        b.tx_done = 1'b1;
        tick();
        b.tx_done = 1'b0;
        n_total++;
        if ({b.done, b.err} !== {4'b0001, 1'b0})
            $display("FAIL nogap_done: got done=%b err=%b want 0001 0", b.done, b.err);
        else n_pass++;
    endtask

    initial begin
        rst        = 1'b1;
        a.req      = '0;
        a.req_data = '0;
        a.tx_done  = 1'b0;
        b.req      = '0;
        b.req_data = '0;
        b.tx_done  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_skip();
        test_reset_mid_wait();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
